// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 16-bit ALU by two requesters.
// Optional opcode legality check: define ALU_ARB_OPCODE_CHECK_EN.
module alu_arbiter #(
  parameter int DATA_W    = 16,
  parameter int OP_W      = 4,
  parameter int START_PRI = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_v,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_s,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state;

  logic              pri;
  logic              gid;
  logic              err_q;
  logic              gnt0;
  logic              gnt1;
  logic              acc;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              legal;

  // Grant: only in IDLE, only to a valid requester, priority breaks ties.
  always_comb begin
    gnt0 = rst_n && (state == IDLE) && req0_valid
           && (!req1_valid || !pri);
    gnt1 = rst_n && (state == IDLE) && req1_valid
           && (!req0_valid || pri);
    acc  = gnt0 || gnt1;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Mux the winning request onto the ALU input path.
  always_comb begin
    sel_op = gnt1 ? req1_op : req0_op;
    sel_a  = gnt1 ? req1_a  : req0_a;
    sel_b  = gnt1 ? req1_b  : req0_b;
  end

`ifdef ALU_ARB_OPCODE_CHECK_EN
  // Legal opcodes: 0, 1, 8, 9, 10, 11.
  always_comb begin
    legal = (sel_op == OP_W'(0))  || (sel_op == OP_W'(1))
         || (sel_op == OP_W'(8))  || (sel_op == OP_W'(9))
         || (sel_op == OP_W'(10)) || (sel_op == OP_W'(11));
  end
`else
  assign legal = 1'b1;
`endif

  // Arbitration FSM: accept, issue for one cycle, hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pri        <= 1'(START_PRI);
      gid        <= 1'b0;
      err_q      <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            gid   <= gnt1;
            err_q <= !legal;
            if (legal) begin
              alu_opcode <= sel_op;
              alu_in1    <= sel_a;
              alu_in2    <= sel_b;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_id  <= gid;
          rsp_err <= err_q;
          if (err_q) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
          end else begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_s, alu_z, alu_c, alu_v};
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            pri       <= ~gid;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
